// File: rtl/bcd_display_scanner.sv
// Multiplexed nine-digit 7-segment scanner for the binary-to-BCD converter.
// Digits are staged on load and promoted to the display only at a frame wrap.
module bcd_display_scanner #(
  parameter int PRESCALE     = 50000,
  parameter int BLANK_CYCLES = 16
) (
  input  logic       Clk,
  input  logic       Reset,
  input  logic       load,
  input  logic [3:0] BCD0,
  input  logic [3:0] BCD1,
  input  logic [3:0] BCD2,
  input  logic [3:0] BCD3,
  input  logic [3:0] BCD4,
  input  logic [3:0] BCD5,
  input  logic [3:0] BCD6,
  input  logic [3:0] BCD7,
  input  logic [3:0] BCD8,
  input  logic       blank_lz,
  output logic [6:0] seg,
  output logic       dp,
  output logic [8:0] an,
  output logic       frame_done
);

  localparam int CW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam logic [CW-1:0] CNT_LAST  = CW'(PRESCALE - 1);
  localparam logic [CW-1:0] BLANK_END = CW'(BLANK_CYCLES);

  logic [CW-1:0]     cnt_q, cnt_d;
  logic [3:0]        idx_q, idx_d;
  logic [8:0][3:0]   stage_q, stage_d;
  logic [8:0][3:0]   disp_q, disp_d;
  logic              pending_q, pending_d;
  logic [6:0]        seg_q, seg_d;
  logic [8:0]        an_q, an_d;
  logic              frame_done_q, frame_done_d;

  logic [8:0][3:0]   bcdIn;
  logic              lastSlot;
  logic              frameEdge;
  logic [8:0]        lzMask;
  logic              allZero;
  logic [3:0]        curDigit;
  logic              curBlank;
  logic [8:0]        anOn;

  assign bcdIn = {BCD8, BCD7, BCD6, BCD5, BCD4, BCD3, BCD2, BCD1, BCD0};

  // Active-low glyphs; codes above 9 show a lone middle bar.
  function automatic logic [6:0] decode(input logic [3:0] v);
    logic [6:0] s;
    case (v)
      4'd0:    s = 7'h40;
      4'd1:    s = 7'h79;
      4'd2:    s = 7'h24;
      4'd3:    s = 7'h30;
      4'd4:    s = 7'h19;
      4'd5:    s = 7'h12;
      4'd6:    s = 7'h02;
      4'd7:    s = 7'h78;
      4'd8:    s = 7'h00;
      4'd9:    s = 7'h10;
      default: s = 7'h3F;
    endcase
    return s;
  endfunction

  assign lastSlot  = (cnt_q == CNT_LAST);
  assign frameEdge = lastSlot && (idx_q == 4'd8);

  always_comb begin
    cnt_d     = lastSlot ? '0 : cnt_q + 1'b1;
    idx_d     = idx_q;
    if (lastSlot) begin
      idx_d = (idx_q == 4'd8) ? 4'd0 : idx_q + 4'd1;
    end
    stage_d   = load ? bcdIn : stage_q;
    pending_d = load ? 1'b1 : (frameEdge ? 1'b0 : pending_q);
    disp_d    = (frameEdge && pending_q) ? stage_q : disp_q;
    frame_done_d = frameEdge;
  end

  // A digit is a leading zero when it and every more significant digit are zero.
  always_comb begin
    lzMask  = '0;
    allZero = 1'b1;
    for (int k = 8; k >= 1; k--) begin
      allZero   = allZero && (disp_q[k] == 4'd0);
      lzMask[k] = allZero;
    end
  end

  always_comb begin
    curDigit = '0;
    curBlank = 1'b0;
    anOn     = 9'h1FF;
    for (int k = 0; k < 9; k++) begin
      if (idx_q == 4'(k)) begin
        curDigit = disp_q[k];
        curBlank = lzMask[k];
        anOn[k]  = 1'b0;
      end
    end
  end

  always_comb begin
    if (cnt_q < BLANK_END) begin
      an_d  = 9'h1FF;
      seg_d = 7'h7F;
    end else begin
      an_d  = anOn;
      seg_d = (blank_lz && curBlank) ? 7'h7F : decode(curDigit);
    end
  end

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      cnt_q        <= '0;
      idx_q        <= '0;
      stage_q      <= '0;
      disp_q       <= '0;
      pending_q    <= 1'b0;
      seg_q        <= 7'h7F;
      an_q         <= 9'h1FF;
      frame_done_q <= 1'b0;
    end else begin
      cnt_q        <= cnt_d;
      idx_q        <= idx_d;
      stage_q      <= stage_d;
      disp_q       <= disp_d;
      pending_q    <= pending_d;
      seg_q        <= seg_d;
      an_q         <= an_d;
      frame_done_q <= frame_done_d;
    end
  end

  assign seg        = seg_q;
  assign an         = an_q;
  assign dp         = 1'b1;
  assign frame_done = frame_done_q;

endmodule

// File: tb/tb_bcd_display_scanner.sv
// Scoreboard bench for bcd_display_scanner: expected slot glyphs are queued per
// frame and a negedge monitor pops one at the start of every lit digit slot.
module tb_bcd_display_scanner;

  logic        Clk = 1'b0;
  logic        Reset;
  logic        load;
  logic        blank_lz;
  logic [35:0] bcdBus;
  wire  [3:0]  BCD0 = bcdBus[3:0];
  wire  [3:0]  BCD1 = bcdBus[7:4];
  wire  [3:0]  BCD2 = bcdBus[11:8];
  wire  [3:0]  BCD3 = bcdBus[15:12];
  wire  [3:0]  BCD4 = bcdBus[19:16];
  wire  [3:0]  BCD5 = bcdBus[23:20];
  wire  [3:0]  BCD6 = bcdBus[27:24];
  wire  [3:0]  BCD7 = bcdBus[31:28];
  wire  [3:0]  BCD8 = bcdBus[35:32];
  logic [6:0]  seg;
  logic        dp;
  logic [8:0]  an;
  logic        frame_done;

  logic [15:0] expQ[$];
  int          total = 0;
  int          bad   = 0;

  bcd_display_scanner #(.PRESCALE(4), .BLANK_CYCLES(1)) dut (
    .Clk(Clk), .Reset(Reset), .load(load),
    .BCD0(BCD0), .BCD1(BCD1), .BCD2(BCD2), .BCD3(BCD3), .BCD4(BCD4),
    .BCD5(BCD5), .BCD6(BCD6), .BCD7(BCD7), .BCD8(BCD8),
    .blank_lz(blank_lz), .seg(seg), .dp(dp), .an(an), .frame_done(frame_done)
  );

  always #5 Clk = ~Clk;

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    total++;
    if (actual !== expected) begin
      bad++;
      $display("[TB] FAIL %s: got %0h expected %0h", name, actual, expected);
    end
  endtask

  // One entry per digit slot: {an, seg}, digit 0 first.
  task automatic pushFrame(input logic [62:0] segs);
    for (int k = 0; k < 9; k++) begin
      logic [8:0] a;
      a = ~(9'b1 << k);
      expQ.push_back({a, segs[7*k +: 7]});
    end
  endtask

  task automatic applyStimulus(input logic [35:0] bcd);
    load   = 1'b1;
    bcdBus = bcd;
    @(negedge Clk);
    load   = 1'b0;
  endtask

  task automatic waitFrame();
    int n = 0;
    do begin
      @(negedge Clk);
      n++;
    end while (!frame_done && n < 100);
    if (!frame_done) checkOutput("frame_timeout", 32'd0, 32'd1);
    checkOutput("queue_drained", expQ.size(), 32'd0);
  endtask

  logic [8:0] prevAn;
  logic [6:0] slotSeg;
  int         onRun, offRun, fdCyc;
  bit         havePrevActive, seenFd;

  // Monitor: slot shape, one-hot enables, frame period and queued glyphs.
  always @(negedge Clk) begin
    if (Reset) begin
      prevAn = 9'h1FF; onRun = 0; offRun = 0; fdCyc = 0;
      havePrevActive = 0; seenFd = 0;
    end else begin
      checkOutput("an_onehot", {31'd0, (an == 9'h1FF) || $onehot(~an)}, 32'd1);
      checkOutput("dp_off", {31'd0, dp}, 32'd1);
      if (an != 9'h1FF) begin
        if (prevAn == 9'h1FF) begin
          if (havePrevActive) checkOutput("off_run", offRun, 32'd1);
          if (expQ.size() > 0) begin
            logic [15:0] e;
            e = expQ.pop_front();
            checkOutput("slot_an_seg", {16'd0, an, seg}, {16'd0, e});
          end
          slotSeg = seg;
          onRun = 1;
        end else begin
          checkOutput("slot_hold", {16'd0, an, seg}, {16'd0, prevAn, slotSeg});
          onRun++;
        end
        offRun = 0;
      end else begin
        if (prevAn != 9'h1FF) begin
          checkOutput("on_run", onRun, 32'd3);
          havePrevActive = 1;
        end
        offRun++;
      end
      fdCyc++;
      if (frame_done) begin
        if (seenFd) checkOutput("frame_period", fdCyc, 32'd36);
        seenFd = 1;
        fdCyc = 0;
      end
      prevAn = an;
    end
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    Reset = 1'b1; load = 1'b0; blank_lz = 1'b0; bcdBus = '0;
    repeat (3) @(negedge Clk);
    checkOutput("reset_seg", {25'd0, seg}, 32'h7F);
    checkOutput("reset_an", {23'd0, an}, 32'h1FF);
    checkOutput("reset_dp", {31'd0, dp}, 32'd1);
    checkOutput("reset_frame_done", {31'd0, frame_done}, 32'd0);

    // Reset release with nothing loaded shows nine zeros.
    pushFrame({9{7'h40}});
    Reset = 1'b0;
    waitFrame();

    // Mid-frame load is held back until the frame wraps.
    blank_lz = 1'b1;
    pushFrame({{8{7'h7F}}, 7'h40});
    repeat (20) @(negedge Clk);
    applyStimulus(36'h000000321);
    waitFrame();

    // Back-to-back loads, then a load on the exact boundary edge.
    pushFrame({{6{7'h7F}}, 7'h30, 7'h24, 7'h79});
    repeat (10) @(negedge Clk);
    applyStimulus(36'h999999999);
    applyStimulus(36'h000000044);
    repeat (23) @(negedge Clk);
    applyStimulus(36'h000000006);
    checkOutput("boundary_frame_done", {31'd0, frame_done}, 32'd1);
    checkOutput("boundary_pending", {31'd0, dut.pending_q}, 32'd1);
    checkOutput("queue_drained", expQ.size(), 32'd0);
    pushFrame({{7{7'h7F}}, 7'h19, 7'h19});
    waitFrame();
    checkOutput("pending_cleared", {31'd0, dut.pending_q}, 32'd0);
    pushFrame({{8{7'h7F}}, 7'h02});

    // Invalid code in digit 5 shows a dash and stops blanking below it.
    repeat (10) @(negedge Clk);
    applyStimulus(36'h000C00000);
    waitFrame();
    pushFrame({{3{7'h7F}}, 7'h3F, {5{7'h40}}});
    waitFrame();

    // Reset during digit 4 with a load pending.
    repeat (3) @(negedge Clk);
    applyStimulus(36'h777777777);
    begin
      int n = 0;
      while (an != 9'h1EF && n < 60) begin
        @(negedge Clk);
        n++;
      end
      checkOutput("reach_idx4", {23'd0, an}, 32'h1EF);
    end
    checkOutput("pending_before_reset", {31'd0, dut.pending_q}, 32'd1);
    #1 Reset = 1'b1;
    #1;
    checkOutput("async_seg", {25'd0, seg}, 32'h7F);
    checkOutput("async_an", {23'd0, an}, 32'h1FF);
    checkOutput("async_frame_done", {31'd0, frame_done}, 32'd0);
    checkOutput("async_pending", {31'd0, dut.pending_q}, 32'd0);
    repeat (3) @(negedge Clk);
    blank_lz = 1'b0;
    pushFrame({9{7'h40}});
    Reset = 1'b0;
    waitFrame();
    pushFrame({9{7'h40}});
    waitFrame();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
